pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 take_branch  input  1  single-cycle redirect request from the branch/jump stage.
REQ-005 newpc  input  32  redirect target, pc+immExt, produced by the branch-target adder.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  instruction memory word address.
REQ-008 imem_ack  input  1  memory response strobe; imem_rdata is valid in this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 if_valid  output  1  fetched instruction is available to decode.
REQ-011 if_ready  input  1  decode accepts the instruction.
REQ-012 if_instr  output  32  fetched instruction.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 pc  output  32  current fetch PC; this value feeds the branch-target adder.

Function
REQ-015 The FSM SHALL have three states: REQ (fetch outstanding), KILL (stale fetch outstanding) and HOLD (instruction presented).
REQ-016 imem_req SHALL be 1 in REQ and KILL and 0 in HOLD; imem_addr SHALL equal pc at all times.
REQ-017 imem_addr SHALL stay stable while imem_req is 1 and imem_ack is 0.
REQ-018 In REQ, when imem_ack=1 and take_branch=0, the unit SHALL do the following on the same edge: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4, go to HOLD.
REQ-019 In REQ, when imem_ack=1 and take_branch=1, the unit SHALL discard imem_rdata, set pc<=newpc and stay in REQ.
REQ-020 In REQ, when imem_ack=0 and take_branch=1, the unit SHALL set redir_pc<=newpc and go to KILL.
REQ-021 In KILL, each take_branch SHALL overwrite redir_pc, so the latest target wins.
REQ-022 In KILL, on imem_ack the unit SHALL discard the data, set pc to redir_pc and go to REQ; if take_branch=1 in the same cycle, pc SHALL be newpc instead.
REQ-023 In HOLD, if_valid SHALL be 1; in all other states if_valid SHALL be 0.
REQ-024 In HOLD, take_branch=1 SHALL set pc<=newpc and go to REQ, with priority over if_ready; the held instruction is dropped.
REQ-025 In HOLD, if_ready=1 with take_branch=0 SHALL go to REQ.
REQ-026 In HOLD, if_ready=0 SHALL keep if_instr and if_pc stable.
REQ-027 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
REQ-028 newpc[1:0] SHALL be ignored; every loaded PC has bits [1:0]=2'b00.
REQ-029 Throughput SHALL be one instruction per two cycles at best, given zero-wait imem_ack and if_ready held at 1.

Reset
REQ-030 While rst_n=0, the unit SHALL hold pc=RESET_PC, redir_pc=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_valid=0, imem_req=0 and state REQ.
REQ-031 imem_req SHALL assert in the first cycle after rst_n rises.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch; a late imem_ack after reset SHALL be treated as the response to the RESET_PC request.

Structure
REQ-033 Package riscv_pkg SHALL hold XLEN=32, the NOP encoding, the fetch FSM state enum and the PC increment constant 4.
REQ-034 One sub-module, pc_next, SHALL be used: a combinational next-PC select over the inputs pc+4, newpc and redir_pc, with alignment masking.

Verification
REQ-035 Reset release with a zero-wait memory returning 0xAAAA0001 and if_ready=1 -> imem_addr 0x0, then if_valid with if_pc=0x0 and if_instr=0xAAAA0001, then imem_addr=0x4.
REQ-036 Hold if_ready=0 for 5 cycles in HOLD -> if_instr and if_pc stable, imem_req=0; on if_ready=1 -> imem_addr=pc+4.
REQ-037 take_branch with newpc=0x34, asserted with imem_ack in REQ -> data discarded, next imem_addr=0x34, no if_valid for the discarded word.
REQ-038 take_branch (newpc=0x18) while imem_ack is delayed 3 cycles -> addr stays at the old value until ack, data discarded, then imem_addr=0x18.
REQ-039 Two take_branch pulses in KILL (0x40, then 0x80) -> refetch at 0x80; newpc=0x2B -> imem_addr=0x28.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0; rst_n pulsed low mid-KILL -> pc=RESET_PC and if_valid=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch front end.
// The fetch FSM encoding and next-PC select codes live here so both RTL files agree.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  // state      | meaning
  // FETCH_REQ  | fetch outstanding at pc
  // FETCH_KILL | stale fetch outstanding, redirect target parked in redir_pc
  // FETCH_HOLD | instruction presented to decode
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'b00,
    FETCH_KILL = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_INC   = 2'b00,
    NPC_NEW   = 2'b01,
    NPC_REDIR = 2'b10
  } npc_sel_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select between sequential, branch and parked redirect targets.
// Every result is word aligned, so a misaligned branch target is silently truncated.
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] newpc,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] pc_nxt
);

  logic [XLEN-1:0] pc_raw;

  always_comb begin
    pc_raw = pc_plus4;
    case (sel)
      NPC_INC:   pc_raw = pc_plus4;
      NPC_NEW:   pc_raw = newpc;
      NPC_REDIR: pc_raw = redir_pc;
      default:   pc_raw = pc_plus4;
    endcase
  end

  assign pc_nxt = align_pc(pc_raw);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at pc, presents the result to decode,
// and handles redirects that arrive before, with, or after the memory response.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        take_branch,
  input  logic [31:0] newpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_sel;
  logic [1:0]      npc_sel;
  logic            pc_load;

  assign pc_plus4 = pc_q + PC_INC;

  pc_next u_pc_next (
    .pc_plus4 (pc_plus4),
    .newpc    (newpc),
    .redir_pc (redir_pc_q),
    .sel      (npc_sel),
    .pc_nxt   (pc_sel)
  );

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    npc_sel    = NPC_INC;
    pc_load    = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        if (imem_ack) begin
          pc_load = 1'b1;
          if (take_branch) begin
            npc_sel = NPC_NEW;
          end else begin
            npc_sel    = NPC_INC;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            state_d    = FETCH_HOLD;
          end
        end else if (take_branch) begin
          // pc must not move while the request is open, so park the target
          redir_pc_d = align_pc(newpc);
          state_d    = FETCH_KILL;
        end
      end

      FETCH_KILL: begin
        if (take_branch) begin
          redir_pc_d = align_pc(newpc);
        end
        if (imem_ack) begin
          pc_load = 1'b1;
          npc_sel = take_branch ? NPC_NEW : NPC_REDIR;
          state_d = FETCH_REQ;
        end
      end

      FETCH_HOLD: begin
        if (take_branch) begin
          pc_load = 1'b1;
          npc_sel = NPC_NEW;
          state_d = FETCH_REQ;
        end else if (if_ready) begin
          state_d = FETCH_REQ;
        end
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    pc_d = pc_load ? pc_sel : pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_REQ;
      pc_q       <= align_pc(RESET_PC);
      redir_pc_q <= '0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // gated by rst_n so the request is quiet during reset yet rises as soon as reset lifts
  assign imem_req  = rst_n & (state_q != FETCH_HOLD);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == FETCH_HOLD);
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign pc        = pc_q;

endmodule
